dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/dbus_pkg.sv | 25 ++
 rtl/dbus_uart_tx.sv | 113 +++++++++++
 rtl/dbus_responder.sv | 110 +++++++++++
 tb/tb_dbus_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared constants and types for the data-bus responder.
// Holds the I/O map, UART_STAT bit positions, FIFO depth and TX states.
package dbus_pkg;

  localparam logic [15:0] UART_DATA = 16'h0020;
  localparam logic [15:0] UART_STAT = 16'h0021;
  localparam logic [15:0] TIMER_LO  = 16'h0022;
  localparam logic [15:0] TIMER_HI  = 16'h0023;
  localparam logic [15:0] RAM_BASE  = 16'h0060;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/dbus_uart_tx.sv
// 4-entry TX FIFO feeding an 8N1 LSB-first transmitter.
// Ports: clock, reset, push/wdata (enqueue), stat_rd (clears overflow),
// full, empty, busy, overflow status, tx serial line (idle high).
module dbus_uart_tx
  import dbus_pkg::*;
#(
  parameter int DIV = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       stat_rd,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(DIV + 1);

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rp;
  logic [PW-1:0] wp;
  logic [PW:0]   cnt;
  tx_state_t     state;
  logic [TW-1:0] tick;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          pop;
  logic          acc;
  logic          tick_end;

  assign full     = (cnt == (PW+1)'(FIFO_DEPTH));
  assign empty    = (cnt == '0);
  assign busy     = (state != TX_IDLE);
  assign pop      = (state == TX_IDLE) && !empty;
  // a pop in the same cycle frees a slot for a push on a full FIFO
  assign acc      = push && (!full || pop);
  assign tick_end = (tick == TW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (acc) fifo[wp] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rp       <= '0;
      wp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      state    <= TX_IDLE;
      tick     <= '0;
      idx      <= '0;
      sh       <= '0;
      tx       <= 1'b1;
    end else begin
      if (acc) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(acc) - (PW+1)'(pop);
      // a new drop outranks the read-clear
      if (push && full && !pop) overflow <= 1'b1;
      else if (stat_rd)         overflow <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          if (pop) begin
            sh    <= fifo[rp];
            tx    <= 1'b0;
            tick  <= '0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (tick_end) begin
            tick  <= '0;
            tx    <= sh[0];
            idx   <= '0;
            state <= TX_DATA;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        TX_DATA: begin
          if (tick_end) begin
            tick <= '0;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              idx <= idx + 3'd1;
              sh  <= sh >> 1;
              tx  <= sh[1];
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        TX_STOP: begin
          if (tick_end) begin
            tick  <= '0;
            state <= TX_IDLE;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// CPU data-bus responder: RAM, UART TX, ms timer, registered read mux.
// Ports: clock, reset, address, wb, w in; din_raw, uart_tx out.
// Macro DBUS_UART_EN builds the UART; without it UART_STAT reads 0x02.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200,
  parameter int RAM_AW = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  wb,
  input  logic        w,
  output logic [7:0]  din_raw,
  output logic        uart_tx
);

  localparam int RAM_BYTES = 1 << RAM_AW;
  localparam int PRE_DIV   = CLK_HZ / 1000;

  logic [7:0]        mem [RAM_BYTES];
  logic [RAM_AW-1:0] ridx;
  logic              ram_sel;
  logic              sel_stat;
  logic              sel_lo;
  logic              sel_hi;
  logic [7:0]        stat;
  logic [7:0]        rdata;
  logic [31:0]       pre;
  logic [15:0]       timer;
  logic [7:0]        shadow;

  assign ridx     = address[RAM_AW-1:0];
  // upper bound stops addresses past the RAM from aliasing onto it
  assign ram_sel  = (address >= RAM_BASE) &&
                    ({16'h0, address} < 32'(RAM_BYTES));
  assign sel_stat = (address == UART_STAT);
  assign sel_lo   = (address == TIMER_LO);
  assign sel_hi   = (address == TIMER_HI);

`ifdef DBUS_UART_EN
  logic u_full;
  logic u_empty;
  logic u_busy;
  logic u_ovf;

  dbus_uart_tx #(
    .DIV (CLK_HZ / BAUD)
  ) u_tx (
    .clock    (clock),
    .reset    (reset),
    .push     (w && (address == UART_DATA)),
    .wdata    (wb),
    .stat_rd  (!w && sel_stat),
    .full     (u_full),
    .empty    (u_empty),
    .busy     (u_busy),
    .overflow (u_ovf),
    .tx       (uart_tx)
  );

  always_comb begin
    stat             = 8'h00;
    stat[STAT_FULL]  = u_full;
    stat[STAT_EMPTY] = u_empty;
    stat[STAT_BUSY]  = u_busy;
    stat[STAT_OVF]   = u_ovf;
  end
`else
  assign uart_tx = 1'b1;
  assign stat    = 8'h02;
`endif

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      ram_sel:  rdata = mem[ridx];
      sel_stat: rdata = stat;
      sel_lo:   rdata = timer[7:0];
      sel_hi:   rdata = shadow;
      default:  rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w && ram_sel) mem[ridx] <= wb;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      din_raw <= 8'h00;
      pre     <= '0;
      timer   <= '0;
      shadow  <= '0;
    end else begin
      din_raw <= rdata;
      if (pre == 32'(PRE_DIV - 1)) begin
        pre   <= '0;
        timer <= timer + 16'd1;
      end else begin
        pre <= pre + 32'd1;
      end
      // freeze the high byte so a LO/HI pair reads one value
      if (!w && sel_lo) shadow <= timer[15:8];
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Randomised self-checking bench for dbus_responder.
// Checks RAM, I/O map, UART frames/FIFO, timer coherence and reset.
module tb_dbus_responder;

  localparam int PRE_M = 1000;
  localparam int PRE_T = 20;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  wb;
  logic        w;
  logic [7:0]  din_raw;
  logic [7:0]  din_t;
  logic        uart_tx;
  logic        tx_t;
  logic        mon_tx;

  int n_chk = 0;
  int n_err = 0;
  int ecnt;
  int last_e;
  int n_abort = 0;

  logic [7:0] rx_q[$];
  bit         rx_ok_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ram_m [int];
  int         wa[$];

  dbus_responder #(
    .CLK_HZ (1000000),
    .BAUD   (100000),
    .RAM_AW (12)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .wb      (wb),
    .w       (w),
    .din_raw (din_raw),
    .uart_tx (uart_tx)
  );

  dbus_responder #(
    .CLK_HZ (20000),
    .BAUD   (2000),
    .RAM_AW (12)
  ) dut_t (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .wb      (wb),
    .w       (w),
    .din_raw (din_t),
    .uart_tx (tx_t)
  );

`ifdef DBUS_UART_EN
  assign mon_tx = uart_tx;
`else
  logic s_full;
  logic s_empty;
  logic s_busy;
  logic s_ovf;
  logic s_tx;
  logic top_tx_low = 1'b0;

  dbus_uart_tx #(
    .DIV (10)
  ) u_sub (
    .clock    (clock),
    .reset    (reset),
    .push     (w && (address == 16'h0020)),
    .wdata    (wb),
    .stat_rd  (!w && (address == 16'h0021)),
    .full     (s_full),
    .empty    (s_empty),
    .busy     (s_busy),
    .overflow (s_ovf),
    .tx       (s_tx)
  );

  assign mon_tx = s_tx;

  always @(negedge clock) begin
    if (uart_tx !== 1'b1) top_tx_low <= 1'b1;
  end
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one bus cycle; after return din_raw holds this cycle's read
  task automatic drive(input logic [15:0] a, input logic wr,
                       input logic [7:0] d);
    address = a;
    w       = wr;
    wb      = d;
    last_e  = ecnt;
    @(posedge clock);
    #1;
    w = 1'b0;
  endtask

  task automatic ram_wr(input int a, input logic [7:0] d);
    drive(16'(a), 1'b1, d);
    if (!ram_m.exists(a)) wa.push_back(a);
    ram_m[a] = d;
  endtask

  task automatic read_stat(output logic [7:0] s);
`ifdef DBUS_UART_EN
    drive(16'h0021, 1'b0, 8'h00);
    s = din_raw;
`else
    s = {4'b0, s_ovf, s_busy, s_empty, s_full};
    drive(16'h0021, 1'b0, 8'h00);
    check("top_stat_off", din_raw, 8'h02);
`endif
  endtask

  task automatic wait_rx(input int n, input int lim);
    int k;
    k = 0;
    while (rx_q.size() < n && k < lim) begin
      drive(16'h0000, 1'b0, 8'h00);
      k++;
    end
    check("rx_count", rx_q.size(), n);
  endtask

  function automatic logic [15:0] tm(input int k, input int pre);
    return 16'((k / pre) % 65536);
  endfunction

  // receiver: frame = start, 8 data LSB first, stop; 10 cycles per bit
  initial begin : rx_mon
    forever begin
      @(posedge clock);
      #2;
      if (!reset && mon_tx === 1'b0) begin
        logic [9:0] f;
        bit ok;
        bit live;
        f    = '0;
        ok   = 1'b1;
        live = 1'b1;
        for (int i = 0; i < 10; i++) begin
          for (int c = 0; c < 10; c++) begin
            if (live) begin
              if (reset) live = 1'b0;
              else begin
                if (c == 0) f[i] = mon_tx;
                else if (mon_tx !== f[i]) ok = 1'b0;
                if (!(i == 9 && c == 9)) begin
                  @(posedge clock);
                  #2;
                end
              end
            end
          end
        end
        if (live) begin
          rx_q.push_back(f[8:1]);
          rx_ok_q.push_back(ok && !f[0] && f[9]);
        end else begin
          n_abort++;
        end
      end
    end
  end

  initial begin : main
    logic [7:0] s;
    logic [7:0] d6 [6];
    logic [7:0] x;
    logic [15:0] v;
    logic [7:0] sh_t;
    logic [7:0] sh_m;
    int a;
    int t0;
    int un [8];

    address = 16'h0000;
    wb      = 8'h00;
    w       = 1'b0;
    reset   = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_din", din_raw, 8'h00);
    check("rst_din_t", din_t, 8'h00);
    check("rst_tx", mon_tx, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    read_stat(s);
    check("stat_init", s, 8'h02);

    // RAM basics and read-before-write
    ram_wr(16'h0100, 8'hA5);
    drive(16'h0100, 1'b0, 8'h00);
    check("ram_a5", din_raw, 8'hA5);
    drive(16'h0000, 1'b0, 8'h00);
    check("rd_0000", din_raw, 8'h00);
    drive(16'h0100, 1'b1, 8'h3C);
    check("rbw_old", din_raw, 8'hA5);
    ram_m[16'h0100] = 8'h3C;
    drive(16'h0100, 1'b0, 8'h00);
    check("rbw_new", din_raw, 8'h3C);

    un = '{16'h0000, 16'h001F, 16'h0024, 16'h005F,
           16'h1000, 16'h1100, 16'hFFFF, 16'h8060};
    foreach (un[i]) drive(16'(un[i]), 1'b1, 8'($urandom));
    foreach (un[i]) begin
      drive(16'(un[i]), 1'b0, 8'h00);
      check("unmapped", din_raw, 8'h00);
    end
    drive(16'h0100, 1'b0, 8'h00);
    check("no_alias", din_raw, ram_m[16'h0100]);

    for (int i = 0; i < 24; i++)
      ram_wr($urandom_range(16'h0060, 16'h0FFF), 8'($urandom));
    for (int i = 0; i < 24; i++) begin
      a = wa[$urandom_range(0, wa.size() - 1)];
      drive(16'(a), 1'b0, 8'h00);
      check("ram_rand", din_raw, ram_m[a]);
    end

    // single frame: line drops one cycle after the write edge
    check("tx_idle", mon_tx, 1'b1);
    drive(16'h0020, 1'b1, 8'h55);
    exp_q.push_back(8'h55);
    check("tx_lat0", mon_tx, 1'b1);
    drive(16'h0000, 1'b0, 8'h00);
    check("tx_start", mon_tx, 1'b0);
    drive(16'h0020, 1'b0, 8'h00);
    check("data_rd0", din_raw, 8'h00);
    wait_rx(1, 200);
    repeat (5) drive(16'h0000, 1'b0, 8'h00);

    // overflow, then a push landing on the full-FIFO pop edge
    for (int i = 0; i < 6; i++) d6[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) drive(16'h0020, 1'b1, d6[i]);
    for (int i = 0; i < 5; i++) exp_q.push_back(d6[i]);
    read_stat(s);
    check("stat_ovf", s, 8'h0D);
    read_stat(s);
    check("stat_ovf_clr", s, 8'h05);
    repeat (94) drive(16'h0000, 1'b0, 8'h00);
    x = 8'($urandom);
    drive(16'h0020, 1'b1, x);
    exp_q.push_back(x);
    read_stat(s);
    check("stat_push_pop", s, 8'h05);
    wait_rx(exp_q.size(), 800);
    repeat (30) drive(16'h0000, 1'b0, 8'h00);
    check("rx_total", rx_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) begin
        check("rx_byte", rx_q[i], exp_q[i]);
        check("rx_frame", rx_ok_q[i], 1'b1);
      end
    end
    read_stat(s);
    check("stat_drained", s, 8'h02);

    // reset during data bit 3
    drive(16'h0020, 1'b1, 8'hF0);
    drive(16'h0020, 1'b1, 8'h81);
    repeat (42) drive(16'h0000, 1'b0, 8'h00);
    drive(16'h0100, 1'b0, 8'h00);
    check("pre_rst_din", din_raw, ram_m[16'h0100]);
    check("tx_bit3", mon_tx, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_mid_tx", mon_tx, 1'b1);
    check("rst_mid_din", din_raw, 8'h00);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    read_stat(s);
    check("rst_mid_stat", s, 8'h02);
    repeat (150) drive(16'h0000, 1'b0, 8'h00);
    check("rst_no_frames", rx_q.size(), exp_q.size());
    check("rst_abort", n_abort, 1);

    // timer coherence across the 0x00FF -> 0x0100 step
    t0 = 255 * PRE_T + PRE_T - 2;
    while (ecnt < t0) drive(16'h0000, 1'b0, 8'h00);
    drive(16'h0022, 1'b0, 8'h00);
    v = tm(last_e, PRE_T);
    check("tlo_t", din_t, v[7:0]);
    sh_t = v[15:8];
    v = tm(last_e, PRE_M);
    check("tlo_m", din_raw, v[7:0]);
    sh_m = v[15:8];
    while (ecnt < 256 * PRE_T + 2) drive(16'h0000, 1'b0, 8'h00);
    drive(16'h0023, 1'b0, 8'h00);
    check("thi_shadow_t", din_t, sh_t);
    check("thi_shadow_m", din_raw, sh_m);

    drive(16'h0022, 1'b1, 8'hAA);
    drive(16'h0023, 1'b1, 8'h55);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 300)) drive(16'h0000, 1'b0, 8'h00);
      drive(16'h0022, 1'b0, 8'h00);
      v = tm(last_e, PRE_T);
      check("tlo_rand", din_t, v[7:0]);
      sh_t = v[15:8];
      repeat ($urandom_range(0, 40)) drive(16'h0000, 1'b0, 8'h00);
      drive(16'h0023, 1'b0, 8'h00);
      check("thi_rand", din_t, sh_t);
    end

`ifndef DBUS_UART_EN
    check("top_tx_high", top_tx_low, 1'b0);
    check("top_tx_now", uart_tx, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
